// File: rtl/mem_access_stage.sv
// Memory-access stage of the pipelined LEGv8 datapath: req/ack data-memory handshake, CBZ resolution, registered writeback bundle.
// Optional macro MEM_ALIGN_CHECK_EN: memory ops with a non-doubleword-aligned address are flagged and never issued.
module mem_access_stage #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         Branch_E,
  input  logic         zero_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         out_valid,
  output logic [N-1:0] readData_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] PCBranch_M,
  output logic         PCSrc_M,
  output logic         misalign_M
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t       state_q, state_d;
  logic         is_write_q, is_write_d;
  logic [N-1:0] dm_addr_q, dm_addr_d;
  logic [N-1:0] dm_wdata_q, dm_wdata_d;
  logic [N-1:0] alu_q, alu_d;
  logic [N-1:0] pcb_q, pcb_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         pcsrc_q, pcsrc_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic         misalign_q, misalign_d;
`endif

  logic accept;
  logic is_mem;
  logic misaligned;

  assign in_ready = (state_q != ACCESS);
  assign accept   = in_valid & in_ready;
  assign is_mem   = MemRead_E | MemWrite_E;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_mem & (aluResult_E[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  // The memory-side address/data registers only load when a transaction is
  // actually issued, so the bus holds its last value between accesses.
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    alu_d      = alu_q;
    pcb_d      = pcb_q;
    rdata_d    = rdata_q;
    pcsrc_d    = pcsrc_q;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          alu_d   = aluResult_E;
          pcb_d   = PCBranch_E;
          pcsrc_d = Branch_E & zero_E;
          rdata_d = '0;
`ifdef MEM_ALIGN_CHECK_EN
          misalign_d = misaligned;
`endif
          if (is_mem && !misaligned) begin
            state_d    = ACCESS;
            is_write_d = MemWrite_E;
            dm_addr_d  = aluResult_E;
            dm_wdata_d = writeData_E;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (dm_ack) begin
          rdata_d = is_write_q ? '0 : dm_rdata;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      alu_q      <= '0;
      pcb_q      <= '0;
      rdata_q    <= '0;
      pcsrc_q    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      alu_q      <= alu_d;
      pcb_q      <= pcb_d;
      rdata_q    <= rdata_d;
      pcsrc_q    <= pcsrc_d;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Handshake outputs decode straight from the state flop so an async reset
  // drops the request in the same instant.
  assign dm_req      = (state_q == ACCESS);
  assign dm_we       = dm_req & is_write_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign out_valid   = (state_q == DONE);
  assign readData_M  = rdata_q;
  assign aluResult_M = alu_q;
  assign PCBranch_M  = pcb_q;
  assign PCSrc_M     = out_valid & pcsrc_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_M = out_valid & misalign_q;
`else
  assign misalign_M = 1'b0;
`endif

  a_req_stable : assert property (@(posedge clk) disable iff (reset)
    (dm_req && !dm_ack) |=> (dm_req && $stable(dm_we) && $stable(dm_addr) && $stable(dm_wdata)));

  a_we_needs_req : assert property (@(posedge clk) disable iff (reset)
    dm_we |-> dm_req);

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: drives execute bundles, plays the
// data memory, and scoreboards every writeback bundle against bench-computed values.
module tb_mem_access_stage;

  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         MemRead_E, MemWrite_E, Branch_E, zero_E;
  logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
  logic         dm_req, dm_we, dm_ack;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         out_valid, PCSrc_M, misalign_M;
  logic [N-1:0] readData_M, aluResult_M, PCBranch_M;

  typedef struct {
    logic [N-1:0] alu;
    logic [N-1:0] pcb;
    logic [N-1:0] rdata;
    logic         pcsrc;
    logic         mis;
  } exp_t;

  exp_t expQ[$];
  int   checks;
  int   fails;

  mem_access_stage #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .Branch_E(Branch_E), .zero_E(zero_E),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .readData_M(readData_M), .aluResult_M(aluResult_M),
    .PCBranch_M(PCBranch_M), .PCSrc_M(PCSrc_M), .misalign_M(misalign_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the bundle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic br, input logic z,
                               input logic [N-1:0] alu, input logic [N-1:0] wd,
                               input logic [N-1:0] pcb, input logic [N-1:0] expRdata,
                               input bit pushExp);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) checkOutput("ready_timeout", 64'd0, 64'd1);
    MemRead_E   = rd;
    MemWrite_E  = wr;
    Branch_E    = br;
    zero_E      = z;
    aluResult_E = alu;
    writeData_E = wd;
    PCBranch_E  = pcb;
    in_valid    = 1'b1;
    e.alu   = alu;
    e.pcb   = pcb;
    e.pcsrc = br & z;
`ifdef MEM_ALIGN_CHECK_EN
    e.mis   = (rd | wr) && (alu[2:0] != 3'b000);
`else
    e.mis   = 1'b0;
`endif
    e.rdata = e.mis ? '0 : expRdata;
    if (pushExp) expQ.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Plays the data memory: checks the held request for k cycles, acks on the last.
  task automatic serveMem(input int k, input logic [N-1:0] rdata, input logic we,
                          input logic [N-1:0] addr, input logic [N-1:0] wdata);
    for (int i = 0; i < k; i++) begin
      checkOutput("dm_req_held", {63'd0, dm_req}, 64'd1);
      checkOutput("dm_we", {63'd0, dm_we}, {63'd0, we});
      checkOutput("dm_addr", dm_addr, addr);
      checkOutput("dm_wdata", dm_wdata, wdata);
      checkOutput("in_ready_busy", {63'd0, in_ready}, 64'd0);
      if (i == k - 1) begin
        dm_ack   = 1'b1;
        dm_rdata = rdata;
      end
      @(posedge clk);
      #1;
      dm_ack   = 1'b0;
      dm_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    checkOutput("out_valid_after_ack", {63'd0, out_valid}, 64'd1);
    checkOutput("dm_req_dropped", {63'd0, dm_req}, 64'd0);
  endtask

  // Scoreboard: every out_valid must match the oldest outstanding bundle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("aluResult_M", aluResult_M, e.alu);
          checkOutput("PCBranch_M", PCBranch_M, e.pcb);
          checkOutput("readData_M", readData_M, e.rdata);
          checkOutput("PCSrc_M", {63'd0, PCSrc_M}, {63'd0, e.pcsrc});
          checkOutput("misalign_M", {63'd0, misalign_M}, {63'd0, e.mis});
        end
      end else begin
        checkOutput("PCSrc_qualified", {63'd0, PCSrc_M}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] a, d, r;
    logic         isWr;
    int           k;
    checks = 0;
    fails  = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    MemRead_E = 1'b0; MemWrite_E = 1'b0; Branch_E = 1'b0; zero_E = 1'b0;
    aluResult_E = '0; writeData_E = '0; PCBranch_E = '0;
    dm_ack = 1'b0;
    dm_rdata = '0;
    #1 reset = 1'b1;
    #1;
    $display("[TB] reset values");
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_dm_req", {63'd0, dm_req}, 64'd0);
    checkOutput("rst_dm_we", {63'd0, dm_we}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_misalign", {63'd0, misalign_M}, 64'd0);
    checkOutput("rst_dm_addr", dm_addr, 64'd0);
    checkOutput("rst_readData", readData_M, 64'd0);
    checkOutput("rst_aluResult", aluResult_M, 64'd0);
    checkOutput("rst_PCBranch", PCBranch_M, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] load with three-cycle ack");
    applyStimulus(1, 0, 0, 0, 64'h10, 64'h0, 64'h0, 64'hFF00_0000_0000_000F, 1);
    serveMem(3, 64'hFF00_0000_0000_000F, 1'b0, 64'h10, 64'h0);

    $display("[TB] store with first-cycle ack");
    applyStimulus(0, 1, 0, 0, 64'h18, 64'hF, 64'h0, 64'h0, 1);
    serveMem(1, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h18, 64'hF);

    $display("[TB] read+write treated as store");
    applyStimulus(1, 1, 0, 0, 64'h20, 64'hAB, 64'h0, 64'h0, 1);
    serveMem(2, 64'h5555_5555_5555_5555, 1'b1, 64'h20, 64'hAB);

    $display("[TB] branch taken and not taken");
    applyStimulus(0, 0, 1, 1, 64'h0, 64'h0, 64'hFC00_0000_0000_003D, 64'h0, 1);
    checkOutput("br_no_req", {63'd0, dm_req}, 64'd0);
    checkOutput("br_out_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("br_dm_addr_held", dm_addr, 64'h20);
    applyStimulus(0, 0, 1, 0, 64'h0, 64'h0, 64'hFC00_0000_0000_003D, 64'h0, 1);
    checkOutput("br_nt_out_valid", {63'd0, out_valid}, 64'd1);

    $display("[TB] back-to-back ALU bundles");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 0, 64'(i), 64'h0, 64'h0, 64'h0, 1);
      checkOutput("b2b_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    checkOutput("idle_after_b2b", {63'd0, out_valid}, 64'd0);

    $display("[TB] random aligned memory ops");
    for (int i = 0; i < 4; i++) begin
      a    = {53'd0, 8'($urandom_range(0, 255)), 3'b000};
      d    = {$urandom, $urandom};
      r    = {$urandom, $urandom};
      isWr = 1'($urandom_range(0, 1));
      k    = $urandom_range(1, 4);
      applyStimulus(!isWr, isWr, 0, 0, a, d, 64'h0, isWr ? 64'h0 : r, 1);
      serveMem(k, r, isWr, a, d);
    end

    $display("[TB] misaligned load");
`ifdef MEM_ALIGN_CHECK_EN
    applyStimulus(1, 0, 0, 0, 64'h13, 64'h0, 64'h0, 64'h0, 1);
    checkOutput("mis_no_req", {63'd0, dm_req}, 64'd0);
    checkOutput("mis_out_valid", {63'd0, out_valid}, 64'd1);
`else
    applyStimulus(1, 0, 0, 0, 64'h13, 64'h0, 64'h0, 64'h0BAD_F00D_0000_0013, 1);
    serveMem(2, 64'h0BAD_F00D_0000_0013, 1'b0, 64'h13, 64'h0);
`endif

    $display("[TB] reset in the middle of an access");
    applyStimulus(1, 0, 0, 0, 64'h40, 64'h0, 64'h0, 64'h0, 0);
    checkOutput("midrst_req_before", {63'd0, dm_req}, 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_req_drop", {63'd0, dm_req}, 64'd0);
    checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    dm_ack   = 1'b1;
    dm_rdata = 64'h7777_7777_7777_7777;
    @(posedge clk);
    #1 dm_ack = 1'b0;
    checkOutput("stray_ack_ignored", {63'd0, out_valid}, 64'd0);
    checkOutput("stray_ack_no_req", {63'd0, dm_req}, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the pipelined 64-bit LEGv8 datapath: consumes the execute-stage results (`aluResult_E`, `writeData_E`, `PCBranch_E`, `zero_E`) and performs the data-memory transaction they describe. It holds the transaction over a multi-cycle req/ack data-memory handshake and stalls the upstream stage meanwhile. It also resolves the conditional-branch decision (`PCSrc_M`) and delivers a registered result bundle to writeback.

## Interface
- `N`, default 64: datapath width (address and data).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: execute bundle valid this cycle.
- `in_ready` out 1: stage can accept a bundle this cycle.
- `MemRead_E` in 1: load.
- `MemWrite_E` in 1: store.
- `Branch_E` in 1: conditional branch (CBZ).
- `zero_E` in 1: ALU zero flag.
- `aluResult_E` in N: address for memory ops, or result otherwise.
- `writeData_E` in N: store data.
- `PCBranch_E` in N: branch target.
- `dm_req` out 1: data-memory request.
- `dm_we` out 1: 1 = write, 0 = read.
- `dm_addr` out N: memory address.
- `dm_wdata` out N: write data.
- `dm_ack` in 1: memory completion, one-cycle pulse.
- `dm_rdata` in N: read data, valid with `dm_ack`.
- `out_valid` out 1: result bundle valid, one-cycle pulse.
- `readData_M` out N: loaded data; 0 for non-loads.
- `aluResult_M` out N: registered `aluResult_E`.
- `PCBranch_M` out N: registered `PCBranch_E`.
- `PCSrc_M` out 1: `Branch & zero`; qualified by `out_valid`, else 0.
- `misalign_M` out 1: misaligned memory op flagged (see Configuration).

## Operation
- States: `IDLE`, `ACCESS`, `DONE`.
- `in_ready` = 1 in `IDLE` and `DONE`, and 0 in `ACCESS`. No downstream backpressure: writeback always accepts.
- **Accept** (`in_valid & in_ready`): latch all `_E` inputs.
  - `MemRead_E | MemWrite_E` → `ACCESS`.
  - Otherwise → `DONE`.
  - `MemRead_E & MemWrite_E` both set: treated as a store.
- **`ACCESS`:**
  - `dm_req` = 1; `dm_we` = latched `MemWrite`.
  - `dm_addr` = latched `aluResult`; `dm_wdata` = latched `writeData`.
  - All four held stable until `dm_ack`.
  - On `dm_ack`: capture `dm_rdata` into `readData_M` if the op is a read, else `readData_M` = 0; go to `DONE`.
- **`DONE`:**
  - `out_valid` = 1 for exactly this cycle.
  - `aluResult_M` and `PCBranch_M` = latched values.
  - `PCSrc_M` = latched `Branch & zero`.
  - A new accept in `DONE` → `ACCESS` or `DONE` per its type. Otherwise → `IDLE`.
- `dm_ack` outside `ACCESS` is ignored.
- `dm_req`, `dm_we` = 0 outside `ACCESS`; `dm_addr`, `dm_wdata` hold their last values.
- **Reset values** (immediate, asynchronous):
  - state `IDLE`.
  - `in_ready` 1.
  - `dm_req`, `dm_we`, `out_valid`, `PCSrc_M`, `misalign_M` = 0.
  - All N-bit outputs = 0.
- **Reset mid-`ACCESS`:** `dm_req` drops in the same instant; the pending transaction is abandoned and produces no `out_valid`.

## Timing
- Non-memory op accepted at edge t → `out_valid` during cycle t..t+1.
- Memory op accepted at edge t:
  - `dm_req` high from t.
  - `dm_ack` sampled at edge t+k (k ≥ 1) → `out_valid` during the following cycle.
  - Latency = k + 1 cycles.
- Back-to-back non-memory ops: one bundle per cycle (`DONE`→`DONE`).
- `dm_ack` in the first `ACCESS` cycle is legal (k = 1).

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- **Defined:** a memory op with `aluResult_E[2:0] != 0` is never issued to memory.
  - Accept → `DONE` directly.
  - `misalign_M` = 1 with `out_valid`.
  - `readData_M` = 0.
  - No `dm_req`.
- **Undefined:**
  - `misalign_M` is tied to 0.
  - Every address is issued unchanged.

## Test plan
- Reset asserted mid-`ACCESS` with `dm_req` = 1 → `dm_req` = 0 immediately, state `IDLE`, no `out_valid` afterwards, `in_ready` = 1.
- Load: `aluResult_E` = 64'h0000_0000_0000_0010, `MemRead_E` = 1; `dm_ack` after 3 cycles with `dm_rdata` = 64'hFF00_0000_0000_000F.
  - `dm_req` held 3 cycles with `dm_addr` = 0x10 and `dm_we` = 0.
  - `in_ready` = 0 throughout.
  - Then `out_valid` = 1 with `readData_M` = 64'hFF00_0000_0000_000F.
- Store: `aluResult_E` = 0x18, `writeData_E` = 0xF, `MemWrite_E` = 1, `dm_ack` on the first cycle.
  - `dm_we` = 1, `dm_wdata` = 0xF.
  - `out_valid` next cycle with `readData_M` = 0.
- Branch: `Branch_E` = 1, `zero_E` = 1, `PCBranch_E` = 64'hFC00_0000_0000_003D.
  - After 1 cycle: `out_valid` = 1, `PCSrc_M` = 1, `PCBranch_M` = 64'hFC00_0000_0000_003D, no `dm_req`.
  - Same with `zero_E` = 0 → `PCSrc_M` = 0.
- Three back-to-back ALU-only bundles (`aluResult_E` = 1, 2, 3) → `out_valid` on 3 consecutive cycles, `aluResult_M` = 1, 2, 3.
- With `MEM_ALIGN_CHECK_EN`: load at address 0x13 → no `dm_req`; `out_valid` with `misalign_M` = 1 and `readData_M` = 0.
  - Without the macro: `dm_req` is issued with `dm_addr` = 0x13.
